// File: rtl/mem_stage_vl_if.sv
// Execute -> memory -> writeback bus for the variable-latency memory stage.
// slave is the stage's own view; master is the surrounding pipeline/SRAM view.
interface mem_stage_vl_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int RA_W   = 5
);
    logic              ws_allowin;
    logic              ms_allowin;
    logic              es_to_ms_valid;
    logic              es_res_from_mem;
    logic [1:0]        es_ld_size;
    logic              es_ld_sign;
    logic              es_gr_we;
    logic [RA_W-1:0]   es_dest;
    logic [DATA_W-1:0] es_alu_result;
    logic [PC_W-1:0]   es_pc;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;
    logic              ms_to_ws_valid;
    logic              ms_ws_gr_we;
    logic [RA_W-1:0]   ms_ws_dest;
    logic [DATA_W-1:0] ms_ws_result;
    logic [PC_W-1:0]   ms_ws_pc;
    logic              ms_fwd_valid;
    logic              ms_fwd_ready;
    logic [RA_W-1:0]   ms_fwd_dest;
    logic [DATA_W-1:0] ms_fwd_data;
    logic              ms_err_stray_ok;
    logic [1:0]        ms_dbg_state;

    modport slave (
        input  ws_allowin, es_to_ms_valid, es_res_from_mem, es_ld_size, es_ld_sign,
               es_gr_we, es_dest, es_alu_result, es_pc, data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_ws_gr_we, ms_ws_dest, ms_ws_result, ms_ws_pc,
               ms_fwd_valid, ms_fwd_ready, ms_fwd_dest, ms_fwd_data, ms_err_stray_ok,
               ms_dbg_state
    );

    modport master (
        output ws_allowin, es_to_ms_valid, es_res_from_mem, es_ld_size, es_ld_sign,
               es_gr_we, es_dest, es_alu_result, es_pc, data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_ws_gr_we, ms_ws_dest, ms_ws_result, ms_ws_pc,
               ms_fwd_valid, ms_fwd_ready, ms_fwd_dest, ms_fwd_data, ms_err_stray_ok,
               ms_dbg_state
    );
endinterface

// File: rtl/mem_stage_vl.sv
// Memory-access pipeline stage with variable-latency SRAM (data_ok strobe),
// load alignment/extension, a one-entry hold buffer for writeback stalls and a forwarding bus.
module mem_stage_vl #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int RA_W   = 5
) (
    input logic          clk,
    input logic          reset,
    mem_stage_vl_if.slave bus
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    // Handshake: a transfer happens on a clock edge where the producer's valid and the
    // consumer's allowin are both 1; valid never depends on allowin of the same hop.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_WAIT = 2'd2,
        ST_HAVE = 2'd3
    } ms_state_e;

    logic              ms_valid_q, ms_valid_d;
    logic              buf_valid_q, buf_valid_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic              res_from_mem_q, res_from_mem_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic              ld_sign_q, ld_sign_d;
    logic              gr_we_q, gr_we_d;
    logic [RA_W-1:0]   dest_q, dest_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [PC_W-1:0]   pc_q, pc_d;

    logic              ld_wait, ms_ready_go, ms_to_ws_valid, ms_allowin, leave, take_ok;
    logic [DATA_W-1:0] lane, ld_ext, result;
    ms_state_e         state;

    always_comb begin
        ld_wait        = ms_valid_q && res_from_mem_q && !buf_valid_q;
        take_ok        = ld_wait && bus.data_sram_data_ok;
        ms_ready_go    = !res_from_mem_q || take_ok || buf_valid_q;
        ms_to_ws_valid = ms_valid_q && ms_ready_go;
        ms_allowin     = !ms_valid_q || (ms_ready_go && bus.ws_allowin);
        leave          = ms_to_ws_valid && bus.ws_allowin;
    end

    // Shifting by the byte offset puts the addressed lane at bit 0 for every size.
    always_comb begin
        lane = bus.data_sram_rdata >> {alu_q[OFF_W-1:0], 3'b000};
        case (ld_size_q)
            2'd0:    ld_ext = ld_sign_q ? DATA_W'($signed(lane[7:0]))  : DATA_W'(lane[7:0]);
            2'd1:    ld_ext = ld_sign_q ? DATA_W'($signed(lane[15:0])) : DATA_W'(lane[15:0]);
            2'd2:    ld_ext = ld_sign_q ? DATA_W'($signed(lane[31:0])) : DATA_W'(lane[31:0]);
            default: ld_ext = lane;
        endcase
        if (!res_from_mem_q)  result = alu_q;
        else if (buf_valid_q) result = buf_data_q;
        else                  result = ld_ext;
    end

    always_comb begin
        ms_valid_d     = ms_allowin ? bus.es_to_ms_valid : ms_valid_q;
        buf_valid_d    = buf_valid_q;
        buf_data_d     = buf_data_q;
        err_d          = err_q || (bus.data_sram_data_ok && !ld_wait);
        res_from_mem_d = res_from_mem_q;
        ld_size_d      = ld_size_q;
        ld_sign_d      = ld_sign_q;
        gr_we_d        = gr_we_q;
        dest_d         = dest_q;
        alu_d          = alu_q;
        pc_d           = pc_q;
        if (leave) begin
            buf_valid_d = 1'b0;
        end else if (take_ok) begin
            buf_valid_d = 1'b1;
            buf_data_d  = ld_ext;
        end
        if (bus.es_to_ms_valid && ms_allowin) begin
            res_from_mem_d = bus.es_res_from_mem;
            ld_size_d      = bus.es_ld_size;
            ld_sign_d      = bus.es_ld_sign;
            gr_we_d        = bus.es_gr_we;
            dest_d         = bus.es_dest;
            alu_d          = bus.es_alu_result;
            pc_d           = bus.es_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            buf_valid_q <= buf_valid_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_data_q     <= buf_data_d;
        res_from_mem_q <= res_from_mem_d;
        ld_size_q      <= ld_size_d;
        ld_sign_q      <= ld_sign_d;
        gr_we_q        <= gr_we_d;
        dest_q         <= dest_d;
        alu_q          <= alu_d;
        pc_q           <= pc_d;
    end

    always_comb begin
        if (!ms_valid_q)          state = ST_IDLE;
        else if (!res_from_mem_q) state = ST_PASS;
        else if (buf_valid_q)     state = ST_HAVE;
        else                      state = ST_WAIT;
    end

    assign bus.ms_allowin      = ms_allowin;
    assign bus.ms_to_ws_valid  = ms_to_ws_valid;
    assign bus.ms_ws_gr_we     = gr_we_q;
    assign bus.ms_ws_dest      = dest_q;
    assign bus.ms_ws_result    = result;
    assign bus.ms_ws_pc        = pc_q;
    assign bus.ms_fwd_valid    = ms_valid_q && gr_we_q && (dest_q != '0);
    assign bus.ms_fwd_ready    = ms_ready_go;
    assign bus.ms_fwd_dest     = dest_q;
    assign bus.ms_fwd_data     = result;
    assign bus.ms_err_stray_ok = err_q;
    assign bus.ms_dbg_state    = state;
endmodule

// File: tb/tb_mem_stage_vl.sv
// Bench for mem_stage_vl: a 32-bit and a 64-bit instance sharing clock and reset,
// with per-instance expected queues popped whenever a result leaves to writeback.
module tb_mem_stage_vl;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [63:0] exp_a_q[$];
    logic [95:0] exp_b_q[$];

    mem_stage_vl_if #(.DATA_W(32), .PC_W(32), .RA_W(5)) a ();
    mem_stage_vl_if #(.DATA_W(64), .PC_W(32), .RA_W(5)) b ();

    mem_stage_vl #(.DATA_W(32), .PC_W(32), .RA_W(5)) u_a (.clk(clk), .reset(reset), .bus(a.slave));
    mem_stage_vl #(.DATA_W(64), .PC_W(32), .RA_W(5)) u_b (.clk(clk), .reset(reset), .bus(b.slave));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // scoreboards
    always @(negedge clk) begin
        if (!reset && a.ms_to_ws_valid && a.ws_allowin) begin
            logic [63:0] e;
            total++;
            if (exp_a_q.size() == 0) begin
                bad++;
                $display("FAIL sb_a_unexpected: got pc=%h res=%h, required no output", a.ms_ws_pc, a.ms_ws_result);
            end else begin
                e = exp_a_q.pop_front();
                if ({a.ms_ws_pc, a.ms_ws_result} !== e) begin
                    bad++;
                    $display("FAIL sb_a: got pc=%h res=%h, required pc=%h res=%h",
                             a.ms_ws_pc, a.ms_ws_result, e[63:32], e[31:0]);
                end
            end
        end
        if (!reset && b.ms_to_ws_valid && b.ws_allowin) begin
            logic [95:0] e;
            total++;
            if (exp_b_q.size() == 0) begin
                bad++;
                $display("FAIL sb_b_unexpected: got pc=%h res=%h, required no output", b.ms_ws_pc, b.ms_ws_result);
            end else begin
                e = exp_b_q.pop_front();
                if ({b.ms_ws_pc, b.ms_ws_result} !== e) begin
                    bad++;
                    $display("FAIL sb_b: got pc=%h res=%h, required pc=%h res=%h",
                             b.ms_ws_pc, b.ms_ws_result, e[95:64], e[63:0]);
                end
            end
        end
    end

    // drivers
    task automatic drive_a(input logic ld, input logic [1:0] size, input logic sign,
                           input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc);
        a.es_to_ms_valid  = 1'b1;
        a.es_res_from_mem = ld;
        a.es_ld_size      = size;
        a.es_ld_sign      = sign;
        a.es_gr_we        = 1'b1;
        a.es_dest         = dest;
        a.es_alu_result   = alu;
        a.es_pc           = pc;
    endtask

    function automatic logic [31:0] ref_ld(input logic [1:0] size, input logic sign,
                                           input logic [1:0] off, input logic [31:0] d);
        logic [7:0]  bt;
        logic [15:0] hw;
        case (off)
            2'd0:    begin bt = d[7:0];   hw = d[15:0];  end
            2'd1:    begin bt = d[15:8];  hw = d[23:8];  end
            2'd2:    begin bt = d[23:16]; hw = d[31:16]; end
            default: begin bt = d[31:24]; hw = 16'h0;    end
        endcase
        case (size)
            2'd0:    return sign ? {{24{bt[7]}}, bt} : {24'h0, bt};
            2'd1:    return sign ? {{16{hw[15]}}, hw} : {16'h0, hw};
            default: return d;
        endcase
    endfunction

    // Load through the 32-bit stage with ws_allowin=1; data_ok comes lat cycles after capture.
    task automatic load32(input logic [1:0] size, input logic sign, input logic [31:0] alu,
                          input logic [31:0] pc, input int lat, input logic [31:0] d,
                          input logic [31:0] exp_res);
        tick;
        drive_a(1'b1, size, sign, 5'd4, alu, pc);
        exp_a_q.push_back({pc, exp_res});
        tick;
        a.es_to_ms_valid = 1'b0;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            total++;
            if (a.ms_to_ws_valid !== 1'b0 || a.ms_allowin !== 1'b0 || a.ms_fwd_ready !== 1'b0) begin
                bad++;
                $display("FAIL load32_wait pc=%h: valid/allowin/fwd_ready=%b%b%b, required 000",
                         pc, a.ms_to_ws_valid, a.ms_allowin, a.ms_fwd_ready);
            end
            tick;
        end
        a.data_sram_data_ok = 1'b1;
        a.data_sram_rdata   = d;
        @(negedge clk);
        total++;
        if (a.ms_to_ws_valid !== 1'b1 || a.ms_allowin !== 1'b1 || a.ms_fwd_ready !== 1'b1 ||
            a.ms_fwd_data !== exp_res) begin
            bad++;
            $display("FAIL load32_ok pc=%h: valid/allowin/fwd_ready=%b%b%b fwd=%h, required 111 fwd=%h",
                     pc, a.ms_to_ws_valid, a.ms_allowin, a.ms_fwd_ready, a.ms_fwd_data, exp_res);
        end
        tick;
        a.data_sram_data_ok = 1'b0;
        a.data_sram_rdata   = $urandom;
    endtask

    task automatic load64(input logic [1:0] size, input logic sign, input logic [63:0] alu,
                          input logic [31:0] pc, input int lat, input logic [63:0] d,
                          input logic [63:0] exp_res);
        tick;
        b.es_to_ms_valid  = 1'b1;
        b.es_res_from_mem = 1'b1;
        b.es_ld_size      = size;
        b.es_ld_sign      = sign;
        b.es_gr_we        = 1'b1;
        b.es_dest         = 5'd9;
        b.es_alu_result   = alu;
        b.es_pc           = pc;
        exp_b_q.push_back({pc, exp_res});
        tick;
        b.es_to_ms_valid = 1'b0;
        repeat (lat) tick;
        b.data_sram_data_ok = 1'b1;
        b.data_sram_rdata   = d;
        @(negedge clk);
        total++;
        if (b.ms_to_ws_valid !== 1'b1 || b.ms_ws_result !== exp_res) begin
            bad++;
            $display("FAIL load64 pc=%h: valid=%b res=%h, required valid=1 res=%h",
                     pc, b.ms_to_ws_valid, b.ms_ws_result, exp_res);
        end
        tick;
        b.data_sram_data_ok = 1'b0;
        b.data_sram_rdata   = {$urandom, $urandom};
    endtask

    // tests
    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (a.ms_to_ws_valid !== 1'b0 || a.ms_fwd_valid !== 1'b0 || a.ms_allowin !== 1'b1 ||
            a.ms_err_stray_ok !== 1'b0 || a.ms_dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_a: valid/fwd/allowin/err=%b%b%b%b st=%0d, required 0010 st=0",
                     a.ms_to_ws_valid, a.ms_fwd_valid, a.ms_allowin, a.ms_err_stray_ok, a.ms_dbg_state);
        end
        total++;
        if (b.ms_to_ws_valid !== 1'b0 || b.ms_allowin !== 1'b1 || b.ms_err_stray_ok !== 1'b0) begin
            bad++;
            $display("FAIL reset_b: valid/allowin/err=%b%b%b, required 010",
                     b.ms_to_ws_valid, b.ms_allowin, b.ms_err_stray_ok);
        end
    endtask

    task automatic test_alu;
        tick;
        drive_a(1'b0, 2'd0, 1'b0, 5'd3, 32'h1234_5678, 32'h0000_0100);
        exp_a_q.push_back({32'h0000_0100, 32'h1234_5678});
        tick;
        a.es_to_ms_valid = 1'b0;
        @(negedge clk);
        total++;
        if (a.ms_to_ws_valid !== 1'b1 || a.ms_fwd_ready !== 1'b1 || a.ms_fwd_valid !== 1'b1 ||
            a.ms_fwd_dest !== 5'd3 || a.ms_ws_dest !== 5'd3 || a.ms_ws_gr_we !== 1'b1) begin
            bad++;
            $display("FAIL alu_out: valid/fwd_ready/fwd_valid=%b%b%b dest=%0d, required 111 dest=3",
                     a.ms_to_ws_valid, a.ms_fwd_ready, a.ms_fwd_valid, a.ms_fwd_dest);
        end
        tick;
        @(negedge clk);
        total++;
        if (a.ms_to_ws_valid !== 1'b0 || a.ms_fwd_valid !== 1'b0) begin
            bad++;
            $display("FAIL alu_drain: valid=%b fwd_valid=%b, required 0 0", a.ms_to_ws_valid, a.ms_fwd_valid);
        end
    endtask

    task automatic test_lb_sign;
        load32(2'd0, 1'b1, 32'h0000_0002, 32'h0000_0104, 3, 32'h0080_0000, 32'hFFFF_FF80);
    endtask

    task automatic test_back_to_back;
        tick;
        drive_a(1'b1, 2'd2, 1'b0, 5'd7, 32'h0000_2000, 32'h0000_0200);
        exp_a_q.push_back({32'h0000_0200, 32'hCAFE_F00D});
        tick;
        drive_a(1'b0, 2'd0, 1'b0, 5'd8, 32'h0000_0077, 32'h0000_0204);
        exp_a_q.push_back({32'h0000_0204, 32'h0000_0077});
        @(negedge clk);
        total++;
        if (a.ms_to_ws_valid !== 1'b0 || a.ms_allowin !== 1'b0 || a.ms_dbg_state !== 2'd2) begin
            bad++;
            $display("FAIL b2b_wait: valid=%b allowin=%b st=%0d, required 0 0 st=2",
                     a.ms_to_ws_valid, a.ms_allowin, a.ms_dbg_state);
        end
        tick;
        a.data_sram_data_ok = 1'b1;
        a.data_sram_rdata   = 32'hCAFE_F00D;
        @(negedge clk);
        total++;
        if (a.ms_to_ws_valid !== 1'b1 || a.ms_allowin !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ok: valid=%b allowin=%b, required 1 1", a.ms_to_ws_valid, a.ms_allowin);
        end
        tick;
        a.es_to_ms_valid    = 1'b0;
        a.data_sram_data_ok = 1'b0;
        @(negedge clk);
        total++;
        if (a.ms_to_ws_valid !== 1'b1 || a.ms_ws_pc !== 32'h0000_0204) begin
            bad++;
            $display("FAIL b2b_second: valid=%b pc=%h, required 1 pc=00000204", a.ms_to_ws_valid, a.ms_ws_pc);
        end
        tick;
        @(negedge clk);
        total++;
        if (a.ms_to_ws_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: valid=%b, required 0", a.ms_to_ws_valid);
        end
    endtask

    task automatic test_random_loads;
        for (int i = 0; i < 16; i++) begin
            logic [1:0]  size, off;
            logic        sign;
            logic [31:0] d, alu;
            size = 2'($urandom_range(0, 2));
            sign = 1'($urandom_range(0, 1));
            off  = (size == 2'd0) ? 2'($urandom_range(0, 3)) :
                   (size == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
            d    = $urandom;
            alu  = {$urandom_range(0, 32'h3FFF_FFFF)} << 2 | {30'h0, off};
            load32(size, sign, alu, 32'h0000_0500 + 32'(4 * i), $urandom_range(0, 3), d,
                   ref_ld(size, sign, off, d));
        end
    endtask

    task automatic test_lhu_stall;
        tick;
        a.ws_allowin = 1'b0;
        drive_a(1'b1, 2'd1, 1'b0, 5'd5, 32'h0000_1002, 32'h0000_0108);
        exp_a_q.push_back({32'h0000_0108, 32'h0000_BEEF});
        tick;
        a.es_to_ms_valid    = 1'b0;
        a.data_sram_data_ok = 1'b1;
        a.data_sram_rdata   = 32'hBEEF_0000;
        @(negedge clk);
        total++;
        if (a.ms_to_ws_valid !== 1'b1 || a.ms_ws_result !== 32'h0000_BEEF || a.ms_allowin !== 1'b0) begin
            bad++;
            $display("FAIL lhu_ok: valid=%b res=%h allowin=%b, required 1 0000beef 0",
                     a.ms_to_ws_valid, a.ms_ws_result, a.ms_allowin);
        end
        for (int c = 0; c < 3; c++) begin
            tick;
            a.data_sram_data_ok = (c == 1);
            a.data_sram_rdata   = (c == 1) ? 32'h1234_0000 : $urandom;
            @(negedge clk);
            total++;
            if (a.ms_to_ws_valid !== 1'b1 || a.ms_ws_result !== 32'h0000_BEEF || a.ms_dbg_state !== 2'd3 ||
                a.ms_allowin !== 1'b0) begin
                bad++;
                $display("FAIL lhu_hold%0d: valid=%b res=%h st=%0d allowin=%b, required 1 0000beef st=3 0",
                         c, a.ms_to_ws_valid, a.ms_ws_result, a.ms_dbg_state, a.ms_allowin);
            end
        end
        total++;
        if (a.ms_err_stray_ok !== 1'b1) begin
            bad++;
            $display("FAIL lhu_stray: err=%b, required 1", a.ms_err_stray_ok);
        end
        tick;
        a.data_sram_data_ok = 1'b0;
        a.ws_allowin        = 1'b1;
        drive_a(1'b0, 2'd0, 1'b0, 5'd6, 32'h0000_A5A5, 32'h0000_010C);
        exp_a_q.push_back({32'h0000_010C, 32'h0000_A5A5});
        @(negedge clk);
        total++;
        if (a.ms_allowin !== 1'b1 || a.ms_ws_result !== 32'h0000_BEEF) begin
            bad++;
            $display("FAIL lhu_leave: allowin=%b res=%h, required 1 0000beef", a.ms_allowin, a.ms_ws_result);
        end
        tick;
        a.es_to_ms_valid = 1'b0;
        @(negedge clk);
        total++;
        if (a.ms_dbg_state !== 2'd1 || a.ms_ws_result !== 32'h0000_A5A5 || a.ms_ws_pc !== 32'h0000_010C) begin
            bad++;
            $display("FAIL lhu_next: st=%0d res=%h pc=%h, required st=1 0000a5a5 0000010c",
                     a.ms_dbg_state, a.ms_ws_result, a.ms_ws_pc);
        end
    endtask

    task automatic test_dword64;
        load64(2'd3, 1'b0, 64'h0, 32'h0000_0300, 1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
        load64(2'd2, 1'b1, 64'h4, 32'h0000_0308, 0, 64'h8000_0000_1234_5678, 64'hFFFF_FFFF_8000_0000);
        load64(2'd2, 1'b0, 64'h0, 32'h0000_0310, 2, 64'h1111_1111_F000_0000, 64'h0000_0000_F000_0000);
        load64(2'd1, 1'b1, 64'h6, 32'h0000_0318, 0, 64'h8001_0000_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
        load64(2'd0, 1'b0, 64'h7, 32'h0000_0320, 1, 64'hAB00_0000_0000_00FF, 64'h0000_0000_0000_00AB);
    endtask

    task automatic test_stray_reset;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        a.data_sram_data_ok = 1'b1;
        tick;
        a.data_sram_data_ok = 1'b0;
        @(negedge clk);
        total++;
        if (a.ms_err_stray_ok !== 1'b1 || a.ms_to_ws_valid !== 1'b0) begin
            bad++;
            $display("FAIL stray_idle: err=%b valid=%b, required 1 0", a.ms_err_stray_ok, a.ms_to_ws_valid);
        end
        tick;
        drive_a(1'b1, 2'd2, 1'b0, 5'd10, 32'h0000_0000, 32'h0000_0400);
        tick;
        a.es_to_ms_valid = 1'b0;
        @(negedge clk);
        total++;
        if (a.ms_dbg_state !== 2'd2 || a.ms_err_stray_ok !== 1'b1 || a.ms_allowin !== 1'b0) begin
            bad++;
            $display("FAIL stray_wait: st=%0d err=%b allowin=%b, required st=2 1 0",
                     a.ms_dbg_state, a.ms_err_stray_ok, a.ms_allowin);
        end
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (a.ms_to_ws_valid !== 1'b0 || a.ms_dbg_state !== 2'd0 || a.ms_err_stray_ok !== 1'b0 ||
            a.ms_allowin !== 1'b1 || a.ms_fwd_valid !== 1'b0) begin
            bad++;
            $display("FAIL stray_after_reset: valid=%b st=%0d err=%b allowin=%b fwd=%b, required 0 st=0 0 1 0",
                     a.ms_to_ws_valid, a.ms_dbg_state, a.ms_err_stray_ok, a.ms_allowin, a.ms_fwd_valid);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        a.ws_allowin = 1'b1; a.es_to_ms_valid = 1'b0; a.es_res_from_mem = 1'b0; a.es_ld_size = 2'd0;
        a.es_ld_sign = 1'b0; a.es_gr_we = 1'b0; a.es_dest = '0; a.es_alu_result = '0; a.es_pc = '0;
        a.data_sram_data_ok = 1'b0; a.data_sram_rdata = '0;
        b.ws_allowin = 1'b1; b.es_to_ms_valid = 1'b0; b.es_res_from_mem = 1'b0; b.es_ld_size = 2'd0;
        b.es_ld_sign = 1'b0; b.es_gr_we = 1'b0; b.es_dest = '0; b.es_alu_result = '0; b.es_pc = '0;
        b.data_sram_data_ok = 1'b0; b.data_sram_rdata = '0;

        test_reset;
        test_alu;
        test_lb_sign;
        test_back_to_back;
        test_random_loads;
        test_lhu_stall;
        test_dword64;
        test_stray_reset;

        tick;
        total++;
        if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: a=%0d b=%0d pending, required 0 0", exp_a_q.size(), exp_b_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage_vl.md
Name: mem_stage_vl

Overview:
- Parametrised successor of the CPU's memory-access pipeline stage; sits between the execute stage and the writeback stage.
- Unlike the single-cycle version, it tolerates a variable-latency data SRAM using a data_ok response strobe.
- Aligns and sign/zero-extends byte, half, word and (for 64-bit) dword loads.
- Buffers a returned load while writeback stalls, and drives a forwarding/hazard bus carrying result data.

Parameters:
- DATA_W, 32: datapath and SRAM data width; legal values 32 or 64.
- PC_W, 32: program counter width.
- RA_W, 5: register-file address width.
- OFF_W, derived as log2(DATA_W/8): byte-offset bits of the address.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- ws_allowin  in  1  writeback stage can accept.
- ms_allowin  out  1  this stage can accept.
- es_to_ms_valid  in  1  execute stage presents an instruction.
- es_res_from_mem  in  1  instruction is a load.
- es_ld_size  in  2  load size: 0 byte, 1 half, 2 word, 3 dword (3 is legal only when DATA_W=64).
- es_ld_sign  in  1  1 = sign-extend, 0 = zero-extend.
- es_gr_we  in  1  register write enable.
- es_dest  in  RA_W  destination register.
- es_alu_result  in  DATA_W  ALU result / load address.
- es_pc  in  PC_W  instruction PC.
- data_sram_data_ok  in  1  load data valid this cycle.
- data_sram_rdata  in  DATA_W  load data.
- ms_to_ws_valid  out  1  result valid to writeback.
- ms_ws_gr_we  out  1  register write enable to writeback.
- ms_ws_dest  out  RA_W  destination to writeback.
- ms_ws_result  out  DATA_W  final result to writeback.
- ms_ws_pc  out  PC_W  PC to writeback.
- ms_fwd_valid  out  1  ms_valid and gr_we and dest != 0.
- ms_fwd_ready  out  1  ms_fwd_data is final (equals ms_ready_go).
- ms_fwd_dest  out  RA_W  forwarding destination.
- ms_fwd_data  out  DATA_W  forwarding data (= ms_ws_result).
- ms_err_stray_ok  out  1  sticky flag: data_ok seen with no load awaiting data.

Behaviour:
- Reset (synchronous): ms_valid=0, buf_valid=0, ms_err_stray_ok=0. Consequently ms_to_ws_valid=0, ms_fwd_valid=0 and ms_allowin=1. Data registers are don't-care.
- Capture: when es_to_ms_valid && ms_allowin, all es_* fields are latched.
- ms_valid update: when ms_allowin, ms_valid <= es_to_ms_valid.
- ms_ready_go is 1 in any of these cases:
  - the instruction is not a load;
  - data_sram_data_ok=1 this cycle while the load waits;
  - buf_valid=1.
- Derived handshake signals:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- Load states:
  - WAIT: ms_valid && load && !buf_valid.
  - HAVE: buf_valid=1.
- Transitions:
  - WAIT with data_ok and ws_allowin: the result passes combinationally from rdata in the same cycle (zero added latency) and the stage may accept the next instruction.
  - WAIT with data_ok and !ws_allowin: the extended data is latched into the buffer and buf_valid <= 1.
  - HAVE: output comes from the buffer. buf_valid clears when the instruction leaves (ms_to_ws_valid && ws_allowin).
  - Back-to-back: if the buffer clears and a new instruction is captured in the same cycle, the new one starts with buf_valid=0.
- Stray data_ok: data_ok while the stage is not in WAIT (including HAVE, a non-load, or !ms_valid).
  - The data is ignored and the buffer is never overwritten.
  - ms_err_stray_ok is set to 1 and stays set until reset.
- Load extraction:
  - off = es_alu_result[OFF_W-1:0] (latched copy).
  - The selected lane starts at byte off, little-endian.
  - size 0 uses rdata[8*off +: 8]; size 1 uses rdata[8*off +: 16].
  - size 2 uses the word at off[OFF_W-1:2]*32 (word offset 0 only when DATA_W=32).
  - size 3 uses the full 64 bits.
  - The lane is extended to DATA_W: sign-extended when es_ld_sign=1, zero-extended otherwise.
  - For word loads, ld_sign is ignored when DATA_W=32.
  - Misaligned offsets are undefined (exceptions are handled upstream).
- Non-load result: ms_ws_result = alu_result.
- Output fields (gr_we, dest, pc) come straight from the latched registers.
- Reset mid-load: the outstanding load is dropped and buf_valid is cleared.
  - A data_ok arriving after reset sets the stray flag; the bench must avoid this or expect it.

Test Plan:
1. Non-load ALU op: alu_result=0x1234_5678, dest=3, ws_allowin=1 -> ms_to_ws_valid in the cycle after capture, ms_ws_result=0x12345678, ms_fwd_ready=1.
2. lb sign, off=2, rdata arrives 3 cycles later = 0x0080_0000 -> ms_to_ws_valid=0 for 3 cycles (ms_allowin=0, ms_fwd_ready=0), then result 0xFFFF_FF80 in the data_ok cycle.
3. lhu off=2, data_ok=0xBEEF_0000 while ws_allowin=0 for 4 cycles -> buf_valid=1, result 0x0000_BEEF held stable; it leaves on the first cycle ws_allowin=1, and the next instruction is captured in that same cycle.
4. Back-to-back: lw followed by an ALU op, data_ok after 1 cycle, ws_allowin=1 -> two consecutive ms_to_ws_valid cycles with correct PCs and no bubble after data_ok.
5. DATA_W=64, ld off=0, rdata=0x8000_0000_0000_0001 -> result matches exactly; lw sign off=4, rdata upper half 0x8000_0000 -> 0xFFFF_FFFF_8000_0000.
6. data_ok pulse while ms_valid=0, then reset asserted during WAIT -> ms_err_stray_ok=1 until reset; after reset ms_valid=0, buf_valid=0, ms_err_stray_ok=0, ms_allowin=1.
